branch_predict_gshare: RTL
==========================

# branch_predict_gshare

Parametrised gshare direction predictor for the 5-stage MIPS pipeline. It supersedes the fixed 8-bit global predictor. History length, PHT depth and counter width are configurable. PHT initialisation runs as a sequential sweep instead of a one-cycle reset. GHR recovery uses a per-branch history snapshot carried down the pipeline. Predictions are made in F and registered into D; the PHT trains in M.

## Interface
Parameters:
- GHR_LEN, 8, global history bits; must satisfy 2 ≤ GHR_LEN ≤ IDX_W.
- IDX_W, 10, PHT index width; PHT depth is 2^IDX_W.
- CNT_W, 2, saturating counter width; must be ≥ 2.
- PC_LSB, 2, lowest PC bit used for indexing.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- flushD  in  1  flush of the D pipeline register.
- stallD  in  1  stall of the D pipeline register.
- pcF  in  32  fetch-stage PC.
- pcM  in  32  memory-stage PC.
- branchD  in  1  D-stage instruction is a conditional branch.
- branchM  in  1  M-stage instruction is a conditional branch.
- actual_takeM  in  1  resolved direction of the M-stage branch.
- pred_wrongM  in  1  M-stage branch was mispredicted.
- ghr_snapM  in  GHR_LEN  ghr_snapD after the pipeline has carried it to M.
- pred_takeF  out  1  F-stage prediction.
- pred_takeD  out  1  branchD & registered pred_takeF.
- ghr_snapD  out  GHR_LEN  GHR value used to index this D instruction's prediction.
- ready  out  1  PHT initialisation complete.

## Operation
- Fetch index: idxF = pcF[PC_LSB+IDX_W-1:PC_LSB] ^ {zeros, ghr}.
- Update index: idxM = pcM[...] ^ {zeros, ghr_snapM}.
- pred_takeF = ready & PHT[idxF][CNT_W-1]. The PHT read is combinational.
- D register: holds pred_takeF and the ghr value used at F.
  - Loads when ~stallD.
  - Clears to 0 on flushD, which has priority over stallD.
- Speculative GHR update: when branchD & ~stallD & ~flushD, ghr <= {ghr[GHR_LEN-2:0], pred_takeD}.
- Recovery: when ready & branchM & pred_wrongM, ghr <= {ghr_snapM[GHR_LEN-2:0], actual_takeM}.
  - Recovery has priority over a simultaneous D update.
- Training: when ready & branchM, PHT[idxM] saturates.
  - actual_takeM=1: increment, capped at 2^CNT_W-1.
  - actual_takeM=0: decrement, floored at 0.
- FSM states:
  - INIT: PHT[ptr] <= 2^(CNT_W-1) (weakly taken); ptr increments each cycle. When ptr = 2^IDX_W-1, go to RUN.
  - RUN: normal operation; ready=1.
- The PHT array has no reset port, so it can be inferred as distributed RAM.

## Timing
- Reset values: state=INIT, ptr=0, ghr=0, D register=0, ready=0, pred_takeF=0, pred_takeD=0, ghr_snapD=0.
- Reset asserted mid-operation: returns to INIT and restarts the sweep from ptr=0.
- Initialisation latency: ready rises 2^IDX_W cycles after rst deasserts (1024 by default).
- During INIT: M-stage training and recovery are ignored. D-stage GHR shifts still occur.
- Prediction latency: F to D is one register stage; pred_takeD is valid the cycle after the F fetch.
- Same-cycle read/write of one PHT entry: the F read returns the old value; the new value is visible next cycle.
- A D update and an M recovery in the same cycle produce the recovery value only.
- ghr wraps by shifting; the oldest bit is dropped.

## Configuration
- GSHARE_STATS_EN defined: adds two outputs.
  - stat_branches, out, 32: increments on ready & branchM.
  - stat_mispred, out, 32: increments on ready & branchM & pred_wrongM.
  - Both reset asynchronously to 0 and wrap modulo 2^32.
- GSHARE_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then idle with default parameters -> ready=0 for 1024 cycles and 1 on cycle 1025; pred_takeF=1 for any pcF after ready.
- Train pcM=0x40, ghr_snapM=0, actual_takeM=0, for 2 branchM cycles -> counter 2→1→0; pred_takeF=0 for pcF=0x40 once ghr=0.
- branchD=1, pred_takeF_r=1 from ghr=8'h00 -> ghr=8'h01 next cycle; with stallD=1 -> ghr unchanged.
- Same cycle: branchD=1 and branchM & pred_wrongM with ghr_snapM=8'hA5, actual_takeM=0 -> ghr=8'h4A.
- Assert rst when ptr=300 during INIT, release -> sweep restarts; ready rises 1024 cycles after release.
- GSHARE_STATS_EN defined: 5 branchM cycles, 2 of them with pred_wrongM -> stat_branches=5, stat_mispred=2.

Source files
------------

// File: rtl/branch_predict_gshare.sv
// branch_predict_gshare: parametrised gshare direction predictor.
// The PHT is indexed by PC bits XOR global history, read combinationally in F,
// registered into D, and trained in M. A sequential sweep initialises the PHT
// to weakly taken; ready rises when the sweep completes.
// Optional feature macro: GSHARE_STATS_EN adds stat_branches / stat_mispred.
module branch_predict_gshare #(
    parameter int GHR_LEN = 8,
    parameter int IDX_W   = 10,
    parameter int CNT_W   = 2,
    parameter int PC_LSB  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flushD,
    input  logic               stallD,
    input  logic [31:0]        pcF,
    input  logic [31:0]        pcM,
    input  logic               branchD,
    input  logic               branchM,
    input  logic               actual_takeM,
    input  logic               pred_wrongM,
    input  logic [GHR_LEN-1:0] ghr_snapM,
    output logic               pred_takeF,
    output logic               pred_takeD,
    output logic [GHR_LEN-1:0] ghr_snapD,
    output logic               ready
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispred
`endif
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] WEAK_TAKEN = {1'b1, {(CNT_W-1){1'b0}}};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_ready;
    logic [GHR_LEN-1:0] r_ghr;
    logic               r_pred_d;
    logic [GHR_LEN-1:0] r_snap_d;
    logic [CNT_W-1:0]   r_pht [DEPTH];

    logic [IDX_W-1:0]   w_idx_f;
    logic [IDX_W-1:0]   w_idx_m;
    logic [CNT_W-1:0]   w_cnt_f;
    logic [CNT_W-1:0]   w_cnt_m;
    logic               w_train;
    logic               w_recover;
    logic               w_shift;
    logic               w_unused_pc;

    // Saturating up/down step of a PHT counter.
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt, input logic up);
        if (up)
            return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
        else
            return (cnt == '0) ? cnt : cnt - CNT_W'(1);
    endfunction

    assign w_idx_f     = pcF[PC_LSB +: IDX_W] ^ IDX_W'(r_ghr);
    assign w_idx_m     = pcM[PC_LSB +: IDX_W] ^ IDX_W'(ghr_snapM);
    assign w_cnt_f     = r_pht[w_idx_f];
    assign w_cnt_m     = r_pht[w_idx_m];
    assign w_train     = r_ready & branchM;
    assign w_recover   = w_train & pred_wrongM;
    assign w_shift     = branchD & ~stallD & ~flushD;
    // Only the index field of each PC matters; fold the rest away.
    assign w_unused_pc = ^{pcF, pcM};

    assign pred_takeF  = r_ready & w_cnt_f[CNT_W-1];
    assign pred_takeD  = branchD & r_pred_d;
    assign ghr_snapD   = r_snap_d;
    assign ready       = r_ready;

    // Init sweep FSM: walk every PHT entry once, then run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_ptr <= r_ptr + IDX_W'(1);
                    if (r_ptr == {IDX_W{1'b1}}) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // PHT storage: sweep writes during INIT, M-stage training afterwards; no reset so it maps to RAM.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT)
            r_pht[r_ptr] <= WEAK_TAKEN;
        else if (w_train)
            r_pht[w_idx_m] <= sat_step(w_cnt_m, actual_takeM);
    end

    // F->D register: flush clears and beats stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_d <= 1'b0;
            r_snap_d <= '0;
        end else if (flushD) begin
            r_pred_d <= 1'b0;
            r_snap_d <= '0;
        end else if (!stallD) begin
            r_pred_d <= pred_takeF;
            r_snap_d <= r_ghr;
        end
    end

    // Global history: mispredict recovery from the M snapshot wins over the speculative D shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ghr <= '0;
        else if (w_recover)
            r_ghr <= {ghr_snapM[GHR_LEN-2:0], actual_takeM};
        else if (w_shift)
            r_ghr <= {r_ghr[GHR_LEN-2:0], pred_takeD};
    end

`ifdef GSHARE_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;

    // Resolved-branch and mispredict counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_train)
                r_stat_br <= r_stat_br + 32'd1;
            if (w_recover)
                r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign stat_branches = r_stat_br;
    assign stat_mispred  = r_stat_mis;
`endif

endmodule
